// File: rtl/voter_if.sv
// Four-seat registered majority voter: one-hot pass/tie/fail verdict plus unanimity flag.
// Build option: define VOTER_IF_CHAIR_TIEBREAK_EN to let the chair seat (I[0]) resolve ties.
module voter_if (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] I,
    output logic [3:0] O
);

    logic [2:0] yes_count;
    logic       pass_d;
    logic       tie_d;
    logic       fail_d;
    logic       unanimous_d;
    logic [3:0] verdict_d;
    logic [3:0] verdict_q;

    always_comb begin
        yes_count = 3'd0;
        for (int i = 0; i < 4; i++) begin
            yes_count = yes_count + {2'b00, I[i]};
        end
    end

    always_comb begin
        pass_d      = (yes_count >= 3'd3);
        tie_d       = (yes_count == 3'd2);
        fail_d      = (yes_count <= 3'd1);
`ifdef VOTER_IF_CHAIR_TIEBREAK_EN
        // Tie stays visible as a flag; the chair's own vote decides the outcome.
        if (tie_d) begin
            pass_d = I[0];
            fail_d = ~I[0];
        end
`endif
        unanimous_d = (I == 4'b0000) || (I == 4'b1111);
        verdict_d   = {unanimous_d, fail_d, tie_d, pass_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            verdict_q <= 4'b0000;
        end else begin
            verdict_q <= verdict_d;
        end
    end

    assign O = verdict_q;

endmodule

// File: tb/tb_voter_if.sv
// Directed self-checking bench for voter_if; expected verdicts are hand-computed per ballot.
module tb_voter_if;

    logic       clk;
    logic       rst;
    logic [3:0] I;
    logic [3:0] O;

    int checks_total;
    int checks_passed;

    voter_if dut (
        .clk (clk),
        .rst (rst),
        .I   (I),
        .O   (O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] expected);
        checks_total++;
        assert (O === expected) checks_passed++;
        else $error("FAIL %s: O=%b expected %b", tag, O, expected);
    endtask

    // Expected verdicts for ballots 0000..1111, index = ballot value.
    logic [3:0] sweep_exp [16];

    initial begin
`ifdef VOTER_IF_CHAIR_TIEBREAK_EN
        sweep_exp = '{4'b1100, 4'b0100, 4'b0100, 4'b0011,
                      4'b0100, 4'b0011, 4'b0110, 4'b0001,
                      4'b0100, 4'b0011, 4'b0110, 4'b0001,
                      4'b0110, 4'b0001, 4'b0001, 4'b1001};
`else
        sweep_exp = '{4'b1100, 4'b0100, 4'b0100, 4'b0010,
                      4'b0100, 4'b0010, 4'b0010, 4'b0001,
                      4'b0100, 4'b0010, 4'b0010, 4'b0001,
                      4'b0010, 4'b0001, 4'b0001, 4'b1001};
`endif
        checks_total  = 0;
        checks_passed = 0;

        // Reset state
        rst = 1'b1;
        I   = 4'b1111;
        repeat (3) @(posedge clk);
        #1 check("reset_hold", 4'b0000);

        // First edge after release samples current ballot
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("first_after_reset", 4'b1001);

        // Asynchronous reset mid-cycle clears O without a clock edge
        #2 rst = 1'b1;
        #1 check("async_reset", 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("release_all_yes", 4'b1001);

        // Exhaustive sweep, one ballot per cycle
        for (int v = 0; v < 16; v++) begin
            I = 4'(v);
            @(posedge clk);
            #1 check($sformatf("sweep_%04b", 4'(v)), sweep_exp[v]);
        end

        // Latency: back-to-back ballots give back-to-back verdicts
        I = 4'b0011;
        @(posedge clk);
        #1 check("latency_0011", sweep_exp[3]);
        I = 4'b0111;
        @(posedge clk);
        #1 check("latency_0111", 4'b0001);

        // Output holds between edges even when I changes
        I = 4'b0000;
        #3 check("hold_between_edges", 4'b0001);
        @(posedge clk);
        #1 check("after_hold_edge", 4'b1100);

        // Tie handling
        I = 4'b0011;
        @(posedge clk);
`ifdef VOTER_IF_CHAIR_TIEBREAK_EN
        #1 check("tie_chair_yes", 4'b0011);
`else
        #1 check("tie_chair_yes", 4'b0010);
`endif
        I = 4'b0110;
        @(posedge clk);
`ifdef VOTER_IF_CHAIR_TIEBREAK_EN
        #1 check("tie_chair_no", 4'b0110);
`else
        #1 check("tie_chair_no", 4'b0010);
`endif

        // Reset mid-stream discards the in-flight ballot
        I = 4'b0111;
        @(posedge clk);
        #1 check("midstream_before", 4'b0001);
        #2 rst = 1'b1;
        #1 check("midstream_async", 4'b0000);
        @(posedge clk);
        #1 check("midstream_held", 4'b0000);
        I = 4'b0001;
        #2 rst = 1'b0;
        @(posedge clk);
        #1 check("midstream_release", 4'b0100);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/voter_if.md
# voter_if

Four-seat registered majority voter for the decision logic. Each clock it counts the yes votes on a 4-bit ballot and registers a one-hot verdict (pass / tie / fail) plus a unanimity flag. It sits between the ballot-collection logic and any downstream consumer of a single decision word.

## Interface
Parameters:
- None. Width is fixed at 4 seats.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset; clears O immediately
- I  input  4  ballot; I[n]=1 is a yes vote from seat n; I[0] is the chair seat
- O  output  4  registered verdict: O[0] pass, O[1] tie, O[2] fail, O[3] unanimous

One clock (clk); reset is asynchronous and active-high (rst).

## Operation
- Yes count: popcount of I, 3-bit unsigned, range 0..4; no overflow possible.
- Verdict without the configuration macro:
  - pass: count >= 3
  - tie: count == 2
  - fail: count <= 1
  - Exactly one of O[2:0] is 1 whenever not in reset.
- Unanimous: O[3]=1 iff I==4'b0000 or I==4'b1111. It is independent of the verdict. Unanimous all-no gives fail+unanimous (4'b1100). Unanimous all-yes gives pass+unanimous (4'b1001).
- Verdict logic is purely combinational from I. Only the final 4-bit word is registered.
- No other state. No memory of earlier ballots.
- I is treated as a fully synchronous input; X/Z on I is not defined behaviour.

## Timing
- Latency: 1 cycle. O at rising edge k+1 reflects I sampled at rising edge k.
- Throughput: one ballot per cycle; back-to-back different ballots produce back-to-back verdicts.
- Reset value: O = 4'b0000. This is the only time O[2:0] is all zero.
- Assertion of rst forces O to 0 asynchronously, without waiting for clk.
- Reset mid-stream: the in-flight ballot is discarded. The first edge with rst low samples the current I, and O updates after that edge.
- A clock edge coincident with rst assertion has no effect; rst wins.
- O holds its value while I is stable; it changes only on edges.

## Configuration
- Macro VOTER_IF_CHAIR_TIEBREAK_EN.
- Undefined: tie handling as in Operation; fail = count <= 1.
- Defined: on count == 2, O[1] (tie) still reads 1, and the chair resolves the outcome:
  - I[0]=1 forces pass=1, fail=0
  - I[0]=0 forces pass=0, fail=1
  - In this mode exactly one of pass/fail is 1 outside reset, and tie is an informational flag.
- Unanimity, latency and reset behaviour are identical in both builds.

## Test plan
- Reset: assert rst with I=4'b1111 mid-cycle -> O=4'b0000 immediately. Deassert rst, then one edge -> O=4'b1001.
- Exhaustive sweep: I=0000..1111, one value per cycle -> O one cycle later:
  - 0000 -> 1100
  - single yes -> 0100
  - two yes -> 0010
  - three yes -> 0001
  - 1111 -> 1001
- Latency check: drive I=0011 then I=0111 on consecutive edges -> O=0010 then 0001 on the following consecutive edges.
- Tie-break (macro defined): I=0011 -> O=4'b0011; I=0110 -> O=4'b0110. With the macro undefined, both give 4'b0010.
- Reset mid-stream: I=0111 sampled, assert rst before the next edge -> O stays 0000. Release rst with I=0001 -> O=0100 after one edge.
